pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the single-cycle LEGv8 datapath: holds the architectural PC, computes next-PC from the branch controls, and detects end-of-program and runaway execution in hardware. It sits between the control unit / ALU zero flag and the instruction memory address port, and responds to the same `startpc`/`currentpc` run protocol the processor bench drives. Halt and watchdog detection move from the bench into RTL, so runs end deterministically on the board.

## Interface
- `PC_WIDTH`, 64, PC and offset width
- `WDOG_WIDTH`, 16, cycle-counter width
- `WDOG_LIMIT`, 16'h00FF, RUN cycle count that forces TIMEOUT

- `CLK`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `startpc`  in  PC_WIDTH  PC loaded while `reset` is high
- `endpc`  in  PC_WIDTH  halt address (unsigned compare)
- `uncond_branch`  in  1  B taken
- `branch`  in  1  conditional branch (CBZ)
- `zero`  in  1  ALU zero flag
- `signext_imm`  in  PC_WIDTH  sign-extended word offset
- `stall`  in  1  hold PC this cycle
- `currentpc`  out  PC_WIDTH  registered PC to instruction memory
- `nextpc`  out  PC_WIDTH  combinational next-PC
- `running`  out  1  state == RUN
- `halted`  out  1  sticky end-of-program flag
- `timeout`  out  1  sticky watchdog flag
- `cycle_count`  out  WDOG_WIDTH  RUN cycles since reset

## Operation
- States: RESET, RUN, HALT, TIMEOUT.
- RESET: entered on any edge with `reset`=1, from any state; `currentpc`<=`startpc`, `cycle_count`<=0. On first edge with `reset`=0, go to RUN.
- Reset values: `currentpc`=`startpc`, `running`=0, `halted`=0, `timeout`=0, `cycle_count`=0.
- take = `uncond_branch` | (`branch` & `zero`).
- `nextpc` = take ? `currentpc` + (`signext_imm` << 2) : `currentpc` + 4; modulo 2^PC_WIDTH, wrap silent.
- RUN edge, priority order:
  - `currentpc` >= `endpc` → HALT, PC unchanged.
  - else `cycle_count`+1 == `WDOG_LIMIT` → TIMEOUT, PC unchanged.
  - else `stall`=1 → PC held.
  - else `currentpc`<=`nextpc`.
- `cycle_count` increments on every RUN edge, stalled or not; saturates at all-ones.
- Simultaneous halt and watchdog conditions: HALT wins; `timeout` stays 0.
- HALT and TIMEOUT are terminal until reset. PC frozen, `cycle_count` frozen. `nextpc` still combinational.
- Branch inputs are ignored outside RUN.

## Timing
- `currentpc` registered: one-edge latency from `nextpc`.
- `nextpc` is combinational within the same cycle, for the single-cycle datapath.
- `halted`/`timeout`/`running` are registered and valid from the edge that enters the state.
- Reset takes effect at the asserting edge. Release takes effect one edge later.
- Reset mid-RUN discards in-flight branch; first post-reset fetch address = `startpc`.

## Configuration
- `PC_SEQ_WATCHDOG_EN` defined: watchdog active as above.
- Not defined:
  - TIMEOUT unreachable; `timeout` tied 0.
  - `cycle_count` still counts and saturates.
  - Only HALT or reset ends RUN.

## Structure
- Package `pc_seq_pkg`:
  - state enum (`PCS_RESET`, `PCS_RUN`, `PCS_HALT`, `PCS_TIMEOUT`)
  - `PC_STEP`=4
  - `BRANCH_SHIFT`=2
  - default width constants
- Sub-module `pc_next_logic`: purely combinational take/adder/mux producing `nextpc`. The state machine, PC register and counter stay in `pc_sequencer`.

## Test plan
- Sequential run: `startpc`=0, `endpc`=0x34, no branches → `currentpc` 0,4,…,0x34, `halted`=1 on the 14th RUN edge, `cycle_count`=14.
- CBZ taken at 0x20: `branch`=1, `zero`=1, `signext_imm`=-3 → next `currentpc`=0x14. With `zero`=0 → 0x24.
- `stall`=1 for 3 cycles at 0x8 → PC holds 0x8 and `cycle_count` advances by 3; after release, 0xC.
- Self-loop (`uncond_branch`=1, imm=0, `endpc`=0x100) → `timeout`=1 when `cycle_count`=0xFF, PC stays 0x0. Macro undefined → no timeout; `cycle_count` saturates at 0xFFFF.
- Reset mid-run at PC 0x18 with `startpc`=0x40 → `currentpc`=0x40 and `running`=0 at the assert edge; `running`=1 one edge after release.
- Wrap: `startpc`=0xFFFF_FFFF_FFFF_FFFC, `endpc`=all-ones → next PC 0x0, no halt until PC ≥ `endpc`. Halt/watchdog coincidence → `halted`=1, `timeout`=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the LEGv8 program-counter sequencer.
// The watchdog is enabled by defining PC_SEQ_WATCHDOG_EN.
package pc_seq_pkg;

    localparam int PC_WIDTH_DEF   = 64;
    localparam int WDOG_WIDTH_DEF = 16;
    localparam int WDOG_LIMIT_DEF = 'h00FF;

    localparam int PC_STEP      = 4;
    localparam int BRANCH_SHIFT = 2;

    typedef enum logic [1:0] {
        PCS_RESET,
        PCS_RUN,
        PCS_HALT,
        PCS_TIMEOUT
    } pcs_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC: branch decision, offset adder and select.
// Wraps modulo 2^PC_WIDTH; no overflow flag is produced.
module pc_next_logic
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] currentpc,
    input  logic                uncond_branch,
    input  logic                branch,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] signext_imm,
    output logic [PC_WIDTH-1:0] nextpc
);

    logic                take;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] br_pc;

    assign take   = uncond_branch | (branch & zero);
    assign seq_pc = currentpc + PC_WIDTH'(PC_STEP);
    assign br_pc  = currentpc + (signext_imm << BRANCH_SHIFT);
    assign nextpc = take ? br_pc : seq_pc;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, run/halt/timeout state machine and RUN cycle counter.
// Optional watchdog: define PC_SEQ_WATCHDOG_EN to enable TIMEOUT.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                    PC_WIDTH   = PC_WIDTH_DEF,
    parameter int                    WDOG_WIDTH = WDOG_WIDTH_DEF,
    parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT =
        WDOG_WIDTH'(WDOG_LIMIT_DEF)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   startpc,
    input  logic [PC_WIDTH-1:0]   endpc,
    input  logic                  uncond_branch,
    input  logic                  branch,
    input  logic                  zero,
    input  logic [PC_WIDTH-1:0]   signext_imm,
    input  logic                  stall,
    output logic [PC_WIDTH-1:0]   currentpc,
    output logic [PC_WIDTH-1:0]   nextpc,
    output logic                  running,
    output logic                  halted,
    output logic                  timeout,
    output logic [WDOG_WIDTH-1:0] cycle_count
);

`ifdef PC_SEQ_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    pcs_state_t            state;
    logic [WDOG_WIDTH-1:0] cc_inc;
    logic [WDOG_WIDTH-1:0] cc_sat;
    logic                  end_hit;
    logic                  wdog_hit;

    pc_next_logic #(
        .PC_WIDTH(PC_WIDTH)
    ) u_next (
        .currentpc    (currentpc),
        .uncond_branch(uncond_branch),
        .branch       (branch),
        .zero         (zero),
        .signext_imm  (signext_imm),
        .nextpc       (nextpc)
    );

    assign cc_inc   = cycle_count + 1'b1;
    assign cc_sat   = (&cycle_count) ? cycle_count : cc_inc;
    assign end_hit  = currentpc >= endpc;
    assign wdog_hit = WDOG_EN && (cc_inc == WDOG_LIMIT);

    // Halt is checked before the watchdog so a coincident end wins.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= PCS_RESET;
            currentpc   <= startpc;
            cycle_count <= '0;
            running     <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            unique case (state)
                PCS_RESET: begin
                    state   <= PCS_RUN;
                    running <= 1'b1;
                end
                PCS_RUN: begin
                    cycle_count <= cc_sat;
                    if (end_hit) begin
                        state   <= PCS_HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (wdog_hit) begin
                        state   <= PCS_TIMEOUT;
                        running <= 1'b0;
                        timeout <= 1'b1;
                    end else if (!stall) begin
                        currentpc <= nextpc;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random runs
// compared against a behavioural model of the sequencer's rules.
module tb_pc_sequencer;

`ifdef PC_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic [63:0] startpc;
    logic [63:0] endpc;
    logic        uncond_branch;
    logic        branch;
    logic        zero;
    logic [63:0] signext_imm;
    logic        stall;
    logic [63:0] currentpc;
    logic [63:0] nextpc;
    logic        running;
    logic        halted;
    logic        timeout;
    logic [15:0] cycle_count;

    pc_sequencer dut (
        .CLK          (CLK),
        .reset        (reset),
        .startpc      (startpc),
        .endpc        (endpc),
        .uncond_branch(uncond_branch),
        .branch       (branch),
        .zero         (zero),
        .signext_imm  (signext_imm),
        .stall        (stall),
        .currentpc    (currentpc),
        .nextpc       (nextpc),
        .running      (running),
        .halted       (halted),
        .timeout      (timeout),
        .cycle_count  (cycle_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
        logic        run;
        logic        hlt;
        logic        to;
        logic [15:0] cc;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state
    logic [63:0] m_pc = '0;
    logic [15:0] m_cc = '0;
    bit          m_rst = 1'b1;
    bit          m_run = 1'b0;
    bit          m_hlt = 1'b0;
    bit          m_to  = 1'b0;

    function automatic logic [63:0] ref_next(input logic [63:0] pc);
        if (uncond_branch || (branch && zero))
            return pc + signext_imm * 64'd4;
        return pc + 64'd4;
    endfunction

    // Advance the model over the coming rising edge and queue the result.
    task automatic tick();
        exp_t        e;
        int unsigned nc;
        if (reset) begin
            m_rst = 1'b1;
            m_run = 1'b0;
            m_hlt = 1'b0;
            m_to  = 1'b0;
            m_pc  = startpc;
            m_cc  = '0;
        end else if (m_rst) begin
            m_rst = 1'b0;
            m_run = 1'b1;
        end else if (m_run) begin
            nc = int'(m_cc) + 1;
            if (m_pc >= endpc) begin
                m_run = 1'b0;
                m_hlt = 1'b1;
            end else if (WD_EN && nc == 255) begin
                m_run = 1'b0;
                m_to  = 1'b1;
            end else if (!stall) begin
                m_pc = ref_next(m_pc);
            end
            m_cc = (nc > 65535) ? 16'hFFFF : nc[15:0];
        end
        e.pc  = m_pc;
        e.npc = ref_next(m_pc);
        e.run = m_run;
        e.hlt = m_hlt;
        e.to  = m_to;
        e.cc  = m_cc;
        sbq.push_back(e);
        @(negedge CLK);
    endtask

    task automatic clr_br();
        uncond_branch = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        signext_imm   = '0;
        stall         = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] sp, input logic [63:0] ep);
        reset   = 1'b1;
        startpc = sp;
        endpc   = ep;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Monitor: one expected entry per rising edge, sampled after the edge
    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            vectors++;
            if (currentpc !== e.pc || nextpc !== e.npc ||
                running !== e.run || halted !== e.hlt ||
                timeout !== e.to || cycle_count !== e.cc) begin
                miscompares++;
                $display("FAIL vec%0d got pc=%h npc=%h run=%b hlt=%b to=%b cc=%h exp pc=%h npc=%h run=%b hlt=%b to=%b cc=%h",
                         vectors, currentpc, nextpc, running, halted,
                         timeout, cycle_count, e.pc, e.npc, e.run,
                         e.hlt, e.to, e.cc);
            end
        end
    end

    initial begin
        int k;
        int guard;
        reset   = 1'b1;
        startpc = '0;
        endpc   = '0;
        clr_br();
        @(negedge CLK);

        // Sequential run to halt at 0x34
        do_reset(64'h0, 64'h34);
        repeat (16) tick();

        // CBZ taken and not taken at 0x20
        do_reset(64'h20, 64'h1000);
        branch      = 1'b1;
        zero        = 1'b1;
        signext_imm = -64'sd3;
        tick();
        clr_br();
        tick();
        do_reset(64'h20, 64'h1000);
        branch      = 1'b1;
        zero        = 1'b0;
        signext_imm = -64'sd3;
        tick();
        clr_br();

        // Stall three cycles at 0x8
        do_reset(64'h0, 64'h1000);
        repeat (2) tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        repeat (2) tick();

        // Reset mid-run with a branch in flight
        do_reset(64'h0, 64'h1000);
        repeat (6) tick();
        reset         = 1'b1;
        startpc       = 64'h40;
        uncond_branch = 1'b1;
        signext_imm   = 64'd5;
        tick();
        reset = 1'b0;
        tick();
        clr_br();
        repeat (2) tick();

        // PC wrap through zero
        do_reset(64'hFFFF_FFFF_FFFF_FFFC, '1);
        repeat (4) tick();

        // Self-loop: watchdog timeout, or counter saturation without it
        do_reset(64'h0, 64'h100);
        uncond_branch = 1'b1;
        repeat (65545) tick();
        clr_br();

        // Halt coinciding with the watchdog edge
        do_reset(64'h0, 64'h100);
        uncond_branch = 1'b1;
        while (m_cc != 16'h00FE) tick();
        endpc = '0;
        repeat (3) tick();
        clr_br();

        // Randomised runs
        for (int r = 0; r < 25; r++) begin
            if (r % 5 == 4)
                do_reset(64'hFFFF_FFFF_FFFF_FF00 +
                         64'($urandom_range(0, 60)) * 4, '1);
            else
                do_reset(64'($urandom_range(0, 64)) * 4,
                         64'($urandom_range(0, 600)));
            for (int s = 0; s < 80; s++) begin
                k             = $urandom_range(0, 12) - 6;
                signext_imm   = 64'(k);
                uncond_branch = ($urandom_range(0, 7) == 0);
                branch        = ($urandom_range(0, 2) == 0);
                zero          = $urandom_range(0, 1) == 1;
                stall         = ($urandom_range(0, 4) == 0);
                reset         = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 29) == 0)
                    endpc = 64'($urandom_range(0, 600));
                tick();
            end
            reset = 1'b0;
            clr_br();
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0",
                     sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
